// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its environment.
// The scheduler takes the slave view; whatever drives the car sensors takes the master view.
interface intersection_scheduler_if;
  logic [3:0] req;
  logic [7:0] lights;
  logic       grant_pulse;
  logic [1:0] grant_id;
  logic [3:0] pending;

  modport master (
    output req,
    input  lights, grant_pulse, grant_id, pending
  );

  modport slave (
    input  req,
    output lights, grant_pulse, grant_id, pending
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Round-robin green/yellow/all-red phase scheduler for a 4-approach intersection.
// Light codes: RED=0, YELLOW=1, GREEN=2; approach i drives lights[2i+1:2i].
module intersection_scheduler #(
  parameter int GREEN_MIN = 8,
  parameter int GREEN_MAX = 20,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 3,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     clear_n,
  intersection_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {ST_GREEN, ST_YELLOW, ST_ALLRED} state_t;

  localparam logic [CNT_W-1:0] GMIN_M1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       cur_q, cur_d;
  logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       pending_q, pending_d;
  logic             grant_pulse_q, grant_pulse_d;

  logic [3:0] green_mask;
  logic       others;
  logic [1:0] next_id;
  logic [1:0] scan_idx;
  logic       found;

  // Rotating scan cur+1, cur+2, cur+3, cur; falls back to approach 0 when nothing is pending.
  always_comb begin
    next_id  = 2'd0;
    found    = 1'b0;
    scan_idx = cur_q;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = cur_q + 2'(k);
      if (!found && pending_q[scan_idx]) begin
        next_id = scan_idx;
        found   = 1'b1;
      end
    end
  end

  assign green_mask = (state_q == ST_GREEN) ? (4'b0001 << cur_q) : 4'b0000;
  assign others     = |(pending_q & ~(4'b0001 << cur_q));

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    green_cnt_d   = green_cnt_q;
    timer_d       = timer_q;
    grant_pulse_d = 1'b0;
    pending_d     = pending_q | (bus.req & ~green_mask);

    case (state_q)
      ST_GREEN: begin
        if (others && (green_cnt_q >= GMIN_M1) &&
            (!bus.req[cur_q] || (green_cnt_q == GMAX_M1))) begin
          state_d = ST_YELLOW;
          timer_d = YEL_M1;
        end else if (green_cnt_q != GMAX_M1) begin
          green_cnt_d = green_cnt_q + CNT_ONE;
        end
      end
      ST_YELLOW: begin
        if (timer_q == '0) begin
          state_d = ST_ALLRED;
          timer_d = AR_M1;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      ST_ALLRED: begin
        if (timer_q == '0) begin
          // Clearing the new holder's request overrides a same-cycle set.
          state_d            = ST_GREEN;
          cur_d              = next_id;
          green_cnt_d        = '0;
          pending_d[next_id] = 1'b0;
          grant_pulse_d      = 1'b1;
        end else begin
          timer_d = timer_q - CNT_ONE;
        end
      end
      default: state_d = ST_GREEN;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= ST_GREEN;
      cur_q         <= 2'd0;
      green_cnt_q   <= '0;
      timer_q       <= '0;
      pending_q     <= 4'b0000;
      grant_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      green_cnt_q   <= green_cnt_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      grant_pulse_q <= grant_pulse_d;
    end
  end

  always_comb begin
    bus.lights = 8'h00;
    case (state_q)
      ST_GREEN:  bus.lights[{cur_q, 1'b0} +: 2] = 2'd2;
      ST_YELLOW: bus.lights[{cur_q, 1'b0} +: 2] = 2'd1;
      default:   bus.lights = 8'h00;
    endcase
  end

  assign bus.grant_pulse = grant_pulse_q;
  assign bus.grant_id    = cur_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Randomized self-checking bench for intersection_scheduler against a
// phase/elapsed-time reference model of the right-of-way rules.
module tb_intersection_scheduler;

  localparam int GREEN_MIN = 8;
  localparam int GREEN_MAX = 20;
  localparam int YELLOW_T  = 4;
  localparam int ALLRED_T  = 3;

  localparam int PH_GREEN  = 0;
  localparam int PH_YELLOW = 1;
  localparam int PH_ALLRED = 2;

  logic clk = 1'b0;
  logic clear_n;

  intersection_scheduler_if bus();

  intersection_scheduler #(
    .GREEN_MIN(GREEN_MIN),
    .GREEN_MAX(GREEN_MAX),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .CNT_W    (8)
  ) dut (
    .clk    (clk),
    .clear_n(clear_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int         m_phase;
  int         m_cur;
  int         m_elapsed;
  logic [3:0] m_pending;
  logic       m_pulse;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_phase   = PH_GREEN;
    m_cur     = 0;
    m_elapsed = 0;
    m_pending = 4'b0000;
    m_pulse   = 1'b0;
  endtask

  function automatic logic [7:0] expLights();
    logic [7:0] l;
    l = 8'h00;
    if (m_phase == PH_GREEN)  l = 8'(2 << (2 * m_cur));
    if (m_phase == PH_YELLOW) l = 8'(1 << (2 * m_cur));
    return l;
  endfunction

  // One clock edge of the reference: r is the req value seen at that edge.
  task automatic modelStep(input logic [3:0] r);
    logic [3:0] np;
    int         nxt;
    bit         others;
    np = m_pending;
    for (int i = 0; i < 4; i++)
      if (r[i] && !(m_phase == PH_GREEN && m_cur == i)) np[i] = 1'b1;
    m_pulse = 1'b0;
    case (m_phase)
      PH_GREEN: begin
        others = 1'b0;
        for (int i = 0; i < 4; i++) if (i != m_cur && m_pending[i]) others = 1'b1;
        if (others && m_elapsed >= GREEN_MIN - 1 &&
            (!r[m_cur] || m_elapsed >= GREEN_MAX - 1)) begin
          m_phase   = PH_YELLOW;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      PH_YELLOW: begin
        if (m_elapsed == YELLOW_T - 1) begin
          m_phase   = PH_ALLRED;
          m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end
      default: begin
        if (m_elapsed == ALLRED_T - 1) begin
          nxt = -1;
          for (int k = 1; k <= 4; k++)
            if (nxt < 0 && m_pending[(m_cur + k) % 4]) nxt = (m_cur + k) % 4;
          if (nxt < 0) nxt = 0;
          np[nxt]   = 1'b0;
          m_cur     = nxt;
          m_phase   = PH_GREEN;
          m_elapsed = 0;
          m_pulse   = 1'b1;
        end else begin
          m_elapsed++;
        end
      end
    endcase
    m_pending = np;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".lights"},   bus.lights,                expLights());
    checkOutput({tag, ".pulse"},    {7'd0, bus.grant_pulse},   {7'd0, m_pulse});
    checkOutput({tag, ".grant_id"}, {6'd0, bus.grant_id},      8'(m_cur));
    checkOutput({tag, ".pending"},  {4'd0, bus.pending},       {4'd0, m_pending});
  endtask

  function automatic logic [3:0] genReq(input int mode);
    logic [3:0] r;
    r = 4'b0000;
    case (mode)
      1: r = 4'b0010;
      2: for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 7) == 0);
      3: begin
        r = 4'b0001;
        if ($urandom_range(0, 15) == 0) r = r | 4'($urandom);
      end
      4: r = 4'($urandom);
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Entered and left at a negedge: check, drive, clock, advance the model.
  task automatic applyStimulus(input string tag, input int mode, input int n);
    for (int c = 0; c < n; c++) begin
      checkAll(tag);
      bus.req = genReq(mode);
      @(posedge clk);
      modelStep(bus.req);
      @(negedge clk);
    end
  endtask

  task automatic resetMidYellow();
    int budget;
    budget = 0;
    while (!(m_phase == PH_YELLOW && m_elapsed < YELLOW_T - 1 && m_pending != 4'b0000)
           && budget < 2000) begin
      applyStimulus("seek", 4, 1);
      budget++;
    end
    if (budget >= 2000) begin
      checkOutput("yellow_wait_timeout", 8'd0, 8'd1);
    end else begin
      checkAll("pre_reset");
      bus.req = 4'b0000;
      @(posedge clk);
      modelStep(bus.req);
      #2 clear_n = 1'b0;
      #1;
      checkOutput("async.lights",   bus.lights,              8'h02);
      checkOutput("async.pending",  {4'd0, bus.pending},     8'h00);
      checkOutput("async.grant_id", {6'd0, bus.grant_id},    8'h00);
      checkOutput("async.pulse",    {7'd0, bus.grant_pulse}, 8'h00);
      modelReset();
      @(negedge clk);
      checkAll("in_reset");
      clear_n = 1'b1;
    end
  endtask

  initial begin
    clear_n = 1'b0;
    bus.req = 4'b0000;
    modelReset();
    repeat (3) @(negedge clk);
    checkAll("reset");
    clear_n = 1'b1;

    applyStimulus("idle",     0, 100);
    applyStimulus("req1",     1, 40);
    applyStimulus("idle2",    0, 30);
    applyStimulus("hold0",    3, 120);
    applyStimulus("sparse",   2, 400);
    applyStimulus("dense",    4, 300);
    resetMidYellow();
    applyStimulus("post_rst", 0, 100);
    applyStimulus("sparse2",  2, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Phase scheduler for a 4-approach intersection.
- Shares the single green right-of-way between approaches 0..3 with round-robin arbitration of latched car requests.
- Sequences each hand-over as GREEN -> YELLOW -> ALL-RED, enforcing minimum and maximum green times.
- Drives per-approach 2-bit light codes using the team encoding: RED=0, YELLOW=1, GREEN=2.

Parameters:
- GREEN_MIN, 8, minimum green duration in cycles (>=1).
- GREEN_MAX, 20, maximum green duration in cycles when any other approach is waiting (>=GREEN_MIN).
- YELLOW_T, 4, yellow duration in cycles (>=1).
- ALLRED_T, 3, all-red clearance duration in cycles (>=1).
- CNT_W, 8, width of the internal timer and green counter; all durations must be < 2**CNT_W.

Ports:
- clk  input  1  single system clock, rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- req  input  4  car-present sensor per approach; level, synchronous to clk.
- lights  output  8  light code per approach; approach i uses lights[2i+1:2i].
- grant_pulse  output  1  one-cycle pulse in the first cycle of each new GREEN.
- grant_id  output  2  approach currently holding right-of-way (green/yellow), or last holder during ALL-RED.
- pending  output  4  latched request bits.

Behaviour:
- Reset, asynchronous on clear_n low:
  - state=GREEN, cur=0, green_cnt=0, timer=0, pending=0, grant_pulse=0, grant_id=0.
  - lights=8'h02 (approach 0 green, others red) immediately, without waiting for a clock edge.
- All outputs are registered; lights is a pure function of the state/cur registers (Moore).
- States:
  - GREEN: lights[cur]=GREEN, others RED.
  - YELLOW: lights[cur]=YELLOW, others RED.
  - ALLRED: all RED.
- Request latch: each edge, pending[i] is set if req[i]=1 and NOT (state==GREEN and cur==i). pending[i] is cleared only on entry to GREEN for approach i. Clear wins over set in that cycle.
- GREEN:
  - green_cnt=0 on the entry cycle, increments every edge, saturates at GREEN_MAX-1.
  - Leave for YELLOW when others = |(pending & ~(1<<cur)) is true and green_cnt >= GREEN_MIN-1, and either req[cur]=0 or green_cnt == GREEN_MAX-1.
  - If others is false, stay GREEN indefinitely regardless of the counter.
  - The load to YELLOW sets timer = YELLOW_T-1.
- YELLOW: timer decrements each edge. At timer==0 go to ALLRED and load timer = ALLRED_T-1. YELLOW therefore lasts exactly YELLOW_T cycles.
- ALLRED:
  - Lasts exactly ALLRED_T cycles.
  - At timer==0, select next = first set bit of pending scanning cur+1, cur+2, cur+3, cur (mod 4 wrap).
  - If pending==0, select approach 0.
  - Enter GREEN with cur=next, green_cnt=0, pending[next] cleared, grant_pulse=1 for that cycle.
- Latency: a request first seen at edge t (other conditions met) earliest produces YELLOW at edge t+1 (the pending register feeds the exit decision).
- Initial green after reset is not announced by grant_pulse.
- Simultaneous requests are resolved strictly by the rotating scan; there is no fixed priority beyond approach order relative to cur.
- req[cur] arriving during YELLOW/ALLRED latches pending[cur]; cur is served again only after the other pending approaches in rotation.
- Reset asserted mid-YELLOW/ALLRED aborts the sequence; no clearance phase is inserted.

Test Plan:
1. Release reset, req=0 for 100 cycles -> lights=8'h02 throughout, grant_pulse never 1, pending=0.
2. req=4'b0010 held from reset release (defaults):
   - lights=8'h02 for exactly 8 cycles, then 8'h01 for 4, then 8'h00 for 3, then 8'h08.
   - grant_pulse=1 and grant_id=1 on the first 8'h08 cycle; pending[1]=0 from then.
3. req[0]=1 held, req[2] pulsed for one cycle at cycle 2 -> pending[2] stays 1; approach 0 green for exactly 20 cycles; then 4 yellow, 3 all-red, lights=8'h20, grant_id=2.
4. req[3:1]=3'b111 pulsed for one cycle while approach 0 is green, then req[0] pulsed during approach 3's green:
   - grants in order 1, 2, 3, 0 (wrap); each green lasts exactly 8 cycles.
   - after the final grant, approach 0 stays green and pending=0.
5. While approach 1 is green, pulse req[1] and req[3] in the same cycle -> pending=4'b1000 (req[1] ignored); next grant is 3.
6. Drive clear_n low asynchronously mid-YELLOW with pending=4'b0110 -> lights=8'h02, pending=0, grant_id=0 before the next clk edge; after release, behaves as scenario 1.
